// File: rtl/dma_line_engine.sv
// -----------------------------------------------------------------------------
// dma_line_engine
//   Fetches a 64-byte cache line as 16 single-word memory beats, or performs a
//   single word write, on behalf of a cache controller.  Beat requests are
//   pipelined: up to 16 reads may be outstanding and data returns in order.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_mode            00 none, 01 line read, 10 word write, 11 illegal
//   req_addr            byte address of the request (sampled in IDLE only)
//   req_wr_data         write word for a word write
//   mem_req/mem_we      beat request / beat is a write
//   mem_addr/mem_wdata  beat byte address / beat write data
//   mem_gnt             beat accepted this cycle
//   mem_rvalid/rdata    read data returned this cycle
//   line_data[0:15]     filled cache line
//   busy                transaction in progress (RD or WR)
//   done                one-cycle completion pulse (first IDLE cycle)
//   err                 one-cycle pulse for an illegal request
// -----------------------------------------------------------------------------
module dma_line_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_mode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wr_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] line_data [0:15],
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0]  MODE_RD   = 2'b01;
   localparam logic [1:0]  MODE_WR   = 2'b10;
   localparam logic [1:0]  MODE_ILL  = 2'b11;
   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q,  addr_d;    // line base in RD, word address in WR
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  issue_q, issue_d;   // beats granted so far (0..16)
   logic [4:0]  ret_q,   ret_d;     // beats returned so far (0..16)
   logic        done_q,  done_d;
   logic        err_q,   err_d;
   logic [31:0] line_q [0:15];
   logic        ret_fire;           // rvalid accepted into the line this cycle

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      issue_d   = issue_q;
      ret_d     = ret_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      ret_fire  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         IDLE: begin
            case (req_mode)
               MODE_RD: begin
                  addr_d  = req_addr & LINE_MASK;
                  issue_d = '0;
                  ret_d   = '0;
                  state_d = RD;
               end
               MODE_WR: begin
                  addr_d  = req_addr & WORD_MASK;
                  wdata_d = req_wr_data;
                  state_d = WR;
               end
               MODE_ILL: err_d = 1'b1;
               default: ;
            endcase
         end

         RD: begin
            // Issue side: address is a pure function of issue_q, so it holds
            // by construction while the grant is withheld.
            if (!issue_q[4]) begin
               mem_req  = 1'b1;
               mem_addr = addr_q + {25'd0, issue_q, 2'b00};
               if (mem_gnt) issue_d = issue_q + 5'd1;
            end
            // Return side runs independently so a grant and an rvalid can
            // land in the same cycle.
            if (mem_rvalid && !ret_q[4]) begin
               ret_fire = 1'b1;
               ret_d    = ret_q + 5'd1;
               if (ret_q == 5'd15) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_gnt) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         issue_q <= '0;
         ret_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < 16; i++) line_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         issue_q <= issue_d;
         ret_q   <= ret_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (ret_fire) line_q[ret_q[3:0]] <= mem_rdata;
      end
   end

   assign line_data = line_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dma_line_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_line_engine
//   Self-checking bench for dma_line_engine.  A memory responder task grants
//   beats (always, randomly, or with a stall on a chosen beat), returns read
//   data in order after a fixed or random latency, and logs every granted
//   address.  Each test task drives requests and compares the logs and the
//   line contents against values computed from the line/word address rules.
// -----------------------------------------------------------------------------
module tb_dma_line_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_mode;
   logic [31:0] req_addr;
   logic [31:0] req_wr_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] line_data [0:15];
   logic        busy;
   logic        done;
   logic        err;

   dma_line_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_mode    (req_mode),
      .req_addr    (req_addr),
      .req_wr_data (req_wr_data),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .line_data   (line_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] data;
   } ret_t;

   int n_checks = 0;
   int n_fail   = 0;

   // responder configuration
   bit          gnt_rand, lat_rand, junk_rv;
   int          wr_delay, stall_beat, stall_left;
   logic [31:0] rd_base;
   // responder observations
   int          wr_wait, rd_beats, rv_cnt, wr_cnt, req_seen;
   int          done_seen, err_seen, both_seen, idle_viol;
   int          done_cyc, last_rv_cyc, wr_gnt_cyc;
   logic [31:0] wr_addr_seen, wr_data_seen;
   logic [31:0] gnt_log[$];
   logic [31:0] stall_log[$];
   ret_t        ret_q[$];
   // expected line contents
   logic [31:0] exp_line [16];

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      stall_log.delete();
      rd_beats = 0; rv_cnt = 0; wr_cnt = 0; wr_wait = 0; req_seen = 0;
      done_seen = 0; err_seen = 0;
      done_cyc = -1; last_rv_cyc = -100; wr_gnt_cyc = -100;
   endtask

   // Memory side: acts at every falling edge, sees the DUT's settled outputs.
   task automatic mem_slave();
      ret_t r;
      int   lat;
      forever begin
         @(negedge clk);
         if (done) begin done_seen++; done_cyc = cyc; end
         if (err) err_seen++;
         if (busy && done) both_seen++;
         if (!mem_req && (mem_we || mem_wdata != 32'd0)) idle_viol++;
         if (mem_req) req_seen++;

         mem_rvalid = 1'b0;
         mem_rdata  = 32'd0;
         if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            mem_rvalid  = 1'b1;
            mem_rdata   = r.data;
            rv_cnt++;
            last_rv_cyc = cyc;
         end else if (junk_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
         end

         mem_gnt = 1'b0;
         if (mem_req && mem_we) begin
            if (wr_wait >= wr_delay) begin
               mem_gnt      = 1'b1;
               wr_addr_seen = mem_addr;
               wr_data_seen = mem_wdata;
               wr_gnt_cyc   = cyc;
               wr_cnt++;
               wr_wait = 0;
            end else wr_wait++;
         end else if (mem_req) begin
            if (stall_left > 0 && rd_beats == stall_beat) begin
               stall_left--;
               stall_log.push_back(mem_addr);
            end else if (!gnt_rand || $urandom_range(0, 1) == 0) begin
               mem_gnt = 1'b1;
               gnt_log.push_back(mem_addr);
               rd_beats++;
               lat    = lat_rand ? int'($urandom_range(1, 6)) : 3;
               r.due  = cyc + lat;
               r.data = rd_base + ((mem_addr >> 2) & 32'hF);
               ret_q.push_back(r);
            end
         end
      end
   endtask

   task automatic start_read(input logic [31:0] a, input logic [31:0] dbase);
      clear_logs();
      rd_base     = dbase;
      req_mode    = 2'b01;
      req_addr    = a;
      req_wr_data = $urandom;
      tick();
      req_mode    = 2'b00;
      req_addr    = $urandom;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d);
      clear_logs();
      req_mode    = 2'b10;
      req_addr    = a;
      req_wr_data = d;
      tick();
      req_mode    = 2'b00;
      req_wr_data = $urandom;
   endtask

   task automatic wait_done(input int limit, output bit to);
      to = 1'b1;
      for (int n = 0; n < limit; n++) begin
         if (done_seen > 0) begin
            to = 1'b0;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [68:0] v;
      int nz;
      rst_n = 1'b0;
      tick(); tick();
      v = {mem_req, mem_we, busy, done, err, mem_addr, mem_wdata};
      n_checks++;
      if (v !== 69'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", v);
      end
      nz = 0;
      for (int i = 0; i < 16; i++) if (line_data[i] !== 32'd0) nz++;
      n_checks++;
      if (nz !== 0) begin
         n_fail++; $display("FAIL reset_line: %0d nonzero words, expected 0", nz);
      end
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_line_read();
      bit to;
      logic [31:0] ea;
      gnt_rand = 0; lat_rand = 0; stall_left = 0;
      start_read(32'h0001_0214, 32'h0000_00A0);
      wait_done(100, to);
      repeat (3) tick();
      n_checks++;
      if (to) begin n_fail++; $display("FAIL read_timeout: no done in 100 cycles"); end
      n_checks++;
      if (gnt_log.size() != 16) begin
         n_fail++; $display("FAIL read_beats: got %0d expected 16", gnt_log.size());
      end
      for (int i = 0; i < 16; i++) begin
         ea = 32'h0001_0200 + 32'(4 * i);
         n_checks++;
         if (i >= gnt_log.size() || gnt_log[i] !== ea) begin
            n_fail++; $display("FAIL read_addr[%0d]: got %h expected %h", i,
                               (i < gnt_log.size()) ? gnt_log[i] : 32'hX, ea);
         end
         exp_line[i] = 32'hA0 + 32'(i);
         n_checks++;
         if (line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL read_line[%0d]: got %h expected %h", i, line_data[i], exp_line[i]);
         end
      end
      n_checks++;
      if (done_seen != 1) begin
         n_fail++; $display("FAIL read_done_count: got %0d expected 1", done_seen);
      end
      n_checks++;
      if (done_cyc != last_rv_cyc + 1) begin
         n_fail++; $display("FAIL read_done_timing: done cycle %0d, last rvalid cycle %0d", done_cyc, last_rv_cyc);
      end
      n_checks++;
      if (both_seen != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL read_busy: busy&done cycles %0d, busy now %b, expected 0/0", both_seen, busy);
      end
      // line must still hold its data while idle
      repeat (5) tick();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL read_hold[%0d]: got %h expected %h", i, line_data[i], exp_line[i]);
         end
      end
   endtask

   task automatic test_gnt_stall();
      bit to;
      logic [31:0] ea;
      gnt_rand = 0; lat_rand = 0;
      clear_logs();
      stall_beat = 5; stall_left = 4;
      start_read(32'h0001_0208, 32'h5000_0000);
      wait_done(100, to);
      repeat (2) tick();
      n_checks++;
      if (to) begin n_fail++; $display("FAIL stall_timeout: no done in 100 cycles"); end
      n_checks++;
      if (stall_log.size() != 4) begin
         n_fail++; $display("FAIL stall_cycles: got %0d expected 4", stall_log.size());
      end
      foreach (stall_log[k]) begin
         n_checks++;
         if (stall_log[k] !== 32'h0001_0214) begin
            n_fail++; $display("FAIL stall_addr_hold[%0d]: got %h expected 00010214", k, stall_log[k]);
         end
      end
      n_checks++;
      if (gnt_log.size() != 16) begin
         n_fail++; $display("FAIL stall_beats: got %0d expected 16", gnt_log.size());
      end
      for (int i = 0; i < 16; i++) begin
         ea = 32'h0001_0200 + 32'(4 * i);
         n_checks++;
         if (i >= gnt_log.size() || gnt_log[i] !== ea) begin
            n_fail++; $display("FAIL stall_addr[%0d]: got %h expected %h", i,
                               (i < gnt_log.size()) ? gnt_log[i] : 32'hX, ea);
         end
         exp_line[i] = 32'h5000_0000 + 32'(i);
         n_checks++;
         if (line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL stall_line[%0d]: got %h expected %h", i, line_data[i], exp_line[i]);
         end
      end
   endtask

   task automatic test_word_write();
      bit to;
      junk_rv = 1; wr_delay = 2;
      start_write(32'h0001_0283, 32'hDEAD_BEEF);
      wait_done(50, to);
      repeat (2) tick();
      junk_rv = 0;
      n_checks++;
      if (to) begin n_fail++; $display("FAIL write_timeout: no done in 50 cycles"); end
      n_checks++;
      if (wr_cnt != 1 || gnt_log.size() != 0) begin
         n_fail++; $display("FAIL write_beats: writes %0d reads %0d, expected 1/0", wr_cnt, gnt_log.size());
      end
      n_checks++;
      if (wr_addr_seen !== 32'h0001_0280) begin
         n_fail++; $display("FAIL write_addr: got %h expected 00010280", wr_addr_seen);
      end
      n_checks++;
      if (wr_data_seen !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL write_data: got %h expected deadbeef", wr_data_seen);
      end
      n_checks++;
      if (req_seen != 3) begin
         n_fail++; $display("FAIL write_req_cycles: got %0d expected 3", req_seen);
      end
      n_checks++;
      if (done_seen != 1 || done_cyc != wr_gnt_cyc + 1) begin
         n_fail++; $display("FAIL write_done: count %0d cycle %0d, gnt cycle %0d", done_seen, done_cyc, wr_gnt_cyc);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL write_line_keep[%0d]: got %h expected %h", i, line_data[i], exp_line[i]);
         end
      end
   endtask

   task automatic test_illegal_and_ignore();
      bit to;
      logic [31:0] ea, db;
      clear_logs();
      junk_rv     = 1;
      req_mode    = 2'b11;
      req_addr    = $urandom;
      tick();
      req_mode    = 2'b00;
      repeat (4) tick();
      junk_rv = 0;
      n_checks++;
      if (err_seen != 1) begin
         n_fail++; $display("FAIL illegal_err: pulses %0d expected 1", err_seen);
      end
      n_checks++;
      if (req_seen != 0 || done_seen != 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL illegal_quiet: req %0d done %0d busy %b, expected 0/0/0", req_seen, done_seen, busy);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL illegal_line_keep[%0d]: got %h expected %h", i, line_data[i], exp_line[i]);
         end
      end

      // a write request arriving mid-read must be dropped
      db = $urandom;
      start_read(32'h0001_03C4, db);
      repeat (3) tick();
      req_mode    = 2'b10;
      req_addr    = 32'h0000_0100;
      req_wr_data = $urandom;
      tick();
      req_mode    = 2'b00;
      wait_done(100, to);
      repeat (4) tick();
      n_checks++;
      if (to || wr_cnt != 0) begin
         n_fail++; $display("FAIL busy_ignore: timeout %b writes %0d, expected 0/0", to, wr_cnt);
      end
      for (int i = 0; i < 16; i++) begin
         ea = 32'h0001_03C0 + 32'(4 * i);
         exp_line[i] = db + 32'(i);
         n_checks++;
         if (i >= gnt_log.size() || gnt_log[i] !== ea || line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL busy_ignore_beat[%0d]: addr %h data %h expected %h/%h", i,
                               (i < gnt_log.size()) ? gnt_log[i] : 32'hX, line_data[i], ea, exp_line[i]);
         end
      end
   endtask

   task automatic test_reset_midread();
      bit to;
      int nz;
      logic [68:0] v;
      logic [31:0] ea, db;
      gnt_rand = 0; lat_rand = 0;
      start_read(32'h0002_0010, $urandom);
      to = 1'b1;
      for (int n = 0; n < 100; n++) begin
         if (rv_cnt >= 8) begin to = 1'b0; break; end
         tick();
      end
      n_checks++;
      if (to) begin n_fail++; $display("FAIL midreset_wait: 8 returns not seen in 100 cycles"); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      v = {mem_req, mem_we, busy, done, err, mem_addr, mem_wdata};
      n_checks++;
      if (v !== 69'd0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h expected 0", v);
      end
      nz = 0;
      for (int i = 0; i < 16; i++) if (line_data[i] !== 32'd0) nz++;
      n_checks++;
      if (nz !== 0) begin
         n_fail++; $display("FAIL midreset_line: %0d nonzero words, expected 0", nz);
      end
      @(negedge clk);
      #3 rst_n = 1'b1;
      clear_logs();
      // let the aborted read's returns arrive while idle
      for (int n = 0; n < 50 && ret_q.size() > 0; n++) tick();
      repeat (2) tick();
      nz = 0;
      for (int i = 0; i < 16; i++) if (line_data[i] !== 32'd0) nz++;
      n_checks++;
      if (nz !== 0 || busy !== 1'b0 || done_seen != 0) begin
         n_fail++; $display("FAIL stale_rvalid: nonzero %0d busy %b done %0d, expected 0/0/0", nz, busy, done_seen);
      end
      db = $urandom;
      start_read(32'h0002_0010, db);
      wait_done(100, to);
      repeat (2) tick();
      n_checks++;
      if (to || gnt_log.size() != 16) begin
         n_fail++; $display("FAIL postreset_read: timeout %b beats %0d, expected 0/16", to, gnt_log.size());
      end
      for (int i = 0; i < 16; i++) begin
         ea = 32'h0002_0000 + 32'(4 * i);
         exp_line[i] = db + 32'(i);
         n_checks++;
         if (i >= gnt_log.size() || gnt_log[i] !== ea || line_data[i] !== exp_line[i]) begin
            n_fail++; $display("FAIL postreset_beat[%0d]: addr %h data %h expected %h/%h", i,
                               (i < gnt_log.size()) ? gnt_log[i] : 32'hX, line_data[i], ea, exp_line[i]);
         end
      end
   endtask

   task automatic test_random();
      bit to;
      logic [31:0] a, d, ea;
      gnt_rand = 1; lat_rand = 1;
      for (int t = 0; t < 10; t++) begin
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            start_read(a, d);
            wait_done(400, to);
            repeat (2) tick();
            n_checks++;
            if (to || gnt_log.size() != 16) begin
               n_fail++; $display("FAIL rand_read[%0d]: timeout %b beats %0d", t, to, gnt_log.size());
            end
            for (int i = 0; i < 16; i++) begin
               ea = (a & 32'hFFFF_FFC0) + 32'(4 * i);
               exp_line[i] = d + 32'(i);
               n_checks++;
               if (i >= gnt_log.size() || gnt_log[i] !== ea || line_data[i] !== exp_line[i]) begin
                  n_fail++; $display("FAIL rand_read[%0d] beat %0d: addr %h data %h expected %h/%h", t, i,
                                     (i < gnt_log.size()) ? gnt_log[i] : 32'hX, line_data[i], ea, exp_line[i]);
               end
            end
         end else begin
            wr_delay = $urandom_range(0, 3);
            start_write(a, d);
            wait_done(50, to);
            repeat (2) tick();
            n_checks++;
            if (to || wr_cnt != 1 || wr_addr_seen !== (a & 32'hFFFF_FFFC) || wr_data_seen !== d
                || done_cyc != wr_gnt_cyc + 1) begin
               n_fail++; $display("FAIL rand_write[%0d]: addr %h data %h expected %h/%h", t,
                                  wr_addr_seen, wr_data_seen, a & 32'hFFFF_FFFC, d);
            end
            for (int i = 0; i < 16; i++) begin
               n_checks++;
               if (line_data[i] !== exp_line[i]) begin
                  n_fail++; $display("FAIL rand_write_keep[%0d] word %0d: got %h expected %h", t, i, line_data[i], exp_line[i]);
               end
            end
         end
         repeat ($urandom_range(0, 3)) tick();
      end
      n_checks++;
      if (both_seen != 0 || idle_viol != 0) begin
         n_fail++; $display("FAIL protocol: busy&done cycles %0d, idle drive cycles %0d, expected 0/0", both_seen, idle_viol);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_mode = 2'b00; req_addr = '0; req_wr_data = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      gnt_rand = 0; lat_rand = 0; junk_rv = 0;
      wr_delay = 0; stall_beat = 0; stall_left = 0; rd_base = '0;
      both_seen = 0; idle_viol = 0;
      clear_logs();
      for (int i = 0; i < 16; i++) exp_line[i] = '0;
      fork
         mem_slave();
      join_none
      test_reset();
      test_line_read();
      test_gnt_stall();
      test_word_write();
      test_illegal_and_ignore();
      test_reset_midread();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
